// File: rtl/arb_wrr_scheduler_if.sv
// rtl/arb_wrr_scheduler_if.sv - request/grant bundle for arb_wrr_scheduler; ARB_ROUND_CNT_EN adds round counter signals
interface arb_wrr_scheduler_if #(
  parameter int P_REQUESTER_NUM = 3,
  parameter int P_WEIGHT_W      = 2
);
  logic [P_REQUESTER_NUM-1:0]            req_i;
  logic [0:P_REQUESTER_NUM*P_WEIGHT_W-1] req_weight_i;
  logic                                  grant_ready_i;
  logic [P_REQUESTER_NUM-1:0]            grant_o;
  logic                                  grant_valid_o;
  logic                                  round_comp_o;
  logic [P_REQUESTER_NUM-1:0]            credit_remain_o;
`ifdef ARB_ROUND_CNT_EN
  logic [15:0]                           round_cnt_o;
  logic                                  round_cnt_clr_i;

  modport master (
    output req_i, req_weight_i, grant_ready_i, round_cnt_clr_i,
    input  grant_o, grant_valid_o, round_comp_o, credit_remain_o, round_cnt_o
  );

  modport slave (
    input  req_i, req_weight_i, grant_ready_i, round_cnt_clr_i,
    output grant_o, grant_valid_o, round_comp_o, credit_remain_o, round_cnt_o
  );
`else
  modport master (
    output req_i, req_weight_i, grant_ready_i,
    input  grant_o, grant_valid_o, round_comp_o, credit_remain_o
  );

  modport slave (
    input  req_i, req_weight_i, grant_ready_i,
    output grant_o, grant_valid_o, round_comp_o, credit_remain_o
  );
`endif
endinterface

// File: rtl/arb_wrr_scheduler.sv
// rtl/arb_wrr_scheduler.sv - weighted round-robin scheduler with per-round credits; ARB_ROUND_CNT_EN adds a 16-bit round counter
module arb_wrr_scheduler #(
  parameter int P_REQUESTER_NUM = 3,
  parameter int P_WEIGHT_W      = 2
) (
  input logic               clk,
  input logic               rst,
  arb_wrr_scheduler_if.slave bus
);
  localparam int N  = P_REQUESTER_NUM;
  localparam int W  = P_WEIGHT_W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    credit_q [N];
  logic [W-1:0]    credit_d [N];
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            round_comp_q, round_comp_d;

  logic [W-1:0]    weight [N];
  logic [N-1:0]    active;
  logic [N-1:0]    eligible;
  logic [N-1:0]    credit_remain;
  logic            pick_found;
  logic [IW-1:0]   pick_idx;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] g);
    return (g == IW'(N - 1)) ? '0 : g + IW'(1);
  endfunction

  // Unpack weights and derive which requesters may take part in the current round.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      weight[i]        = bus.req_weight_i[(i+1)*W-1 -: W];
      active[i]        = bus.req_i[i] & (weight[i] != '0);
      eligible[i]      = active[i] & (credit_q[i] != '0);
      credit_remain[i] = (credit_q[i] != '0);
    end
  end

  // Rotating priority: first eligible requester at or after ptr_q, wrapping at N.
  always_comb begin
    logic [IW:0] cand;
    cand       = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!pick_found && eligible[cand[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IW-1:0];
      end
    end
  end

  // Next-state logic: grant from IDLE, reload credits when the round is spent, hold or release in GRANT.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gidx_d       = gidx_q;
    gnt_d        = gnt_q;
    round_comp_d = 1'b0;
    for (int i = 0; i < N; i++) credit_d[i] = credit_q[i];

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          gidx_d  = pick_idx;
          gnt_d   = N'(1) << pick_idx;
        end else if (active != '0) begin
          // Weights are only sampled here, so mid-round changes wait for the next round.
          for (int i = 0; i < N; i++) credit_d[i] = weight[i];
          round_comp_d = 1'b1;
        end
      end
      GRANT: begin
        if (bus.grant_ready_i) begin
          credit_d[gidx_q] = credit_q[gidx_q] - W'(1);
          if (!(credit_q[gidx_q] != W'(1) && bus.req_i[gidx_q])) begin
            state_d = IDLE;
            gnt_d   = '0;
            ptr_d   = next_idx(gidx_q);
          end
        end else if (!bus.req_i[gidx_q]) begin
          // Withdrawal: release without consuming credit.
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = next_idx(gidx_q);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and credit registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      gidx_q       <= '0;
      gnt_q        <= '0;
      round_comp_q <= 1'b0;
      for (int i = 0; i < N; i++) credit_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gidx_q       <= gidx_d;
      gnt_q        <= gnt_d;
      round_comp_q <= round_comp_d;
      for (int i = 0; i < N; i++) credit_q[i] <= credit_d[i];
    end
  end

  assign bus.grant_o         = gnt_q;
  assign bus.grant_valid_o   = (state_q == GRANT);
  assign bus.round_comp_o    = round_comp_q;
  assign bus.credit_remain_o = credit_remain;

`ifdef ARB_ROUND_CNT_EN
  logic [15:0] round_cnt_q;

  // Count round-completion pulses; a clear beats a coincident increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      round_cnt_q <= '0;
    end else if (bus.round_cnt_clr_i) begin
      round_cnt_q <= '0;
    end else if (round_comp_q) begin
      round_cnt_q <= round_cnt_q + 16'd1;
    end
  end

  assign bus.round_cnt_o = round_cnt_q;
`endif
endmodule

// File: tb/tb_arb_wrr_scheduler.sv
// tb/tb_arb_wrr_scheduler.sv - directed self-checking bench for arb_wrr_scheduler; ARB_ROUND_CNT_EN adds counter checks
module tb_arb_wrr_scheduler;
  localparam int N = 3;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  arb_wrr_scheduler_if #(.P_REQUESTER_NUM(N), .P_WEIGHT_W(W)) bus();

  arb_wrr_scheduler #(.P_REQUESTER_NUM(N), .P_WEIGHT_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Status word per cycle: {round_comp_o, grant_valid_o, grant_o[2:0]}
  logic [4:0] t1 [15] = '{5'b10000, 5'b01001, 5'b01001, 5'b00000, 5'b01010,
                          5'b00000, 5'b01100, 5'b01100, 5'b01100, 5'b00000,
                          5'b10000, 5'b01001, 5'b01001, 5'b00000, 5'b01010};
  logic [4:0] t3 [10] = '{5'b10000, 5'b01001, 5'b01001, 5'b01001, 5'b00000,
                          5'b01100, 5'b01100, 5'b00000, 5'b10000, 5'b01001};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_weights(input int w0, input int w1, input int w2);
    logic [0:N*W-1] v;
    v = '0;
    v[1*W-1 -: W] = W'(w0);
    v[2*W-1 -: W] = W'(w1);
    v[3*W-1 -: W] = W'(w2);
    bus.req_weight_i = v;
  endtask

  task automatic step_check(input string tag, input logic [4:0] exp);
    @(posedge clk);
    #1;
    check(tag, {bus.round_comp_o, bus.grant_valid_o, bus.grant_o}, exp);
  endtask

  // Hold reset for two edges and leave it asserted; the caller releases it.
  task automatic apply_reset();
    rst = 1'b1;
    bus.req_i = '0;
    bus.grant_ready_i = 1'b0;
`ifdef ARB_ROUND_CNT_EN
    bus.round_cnt_clr_i = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_weights(0, 0, 0);

    // Test 1: weights {2,1,3}, all requesting, ready held high.
    apply_reset();
    check("reset_status", {bus.round_comp_o, bus.grant_valid_o, bus.grant_o}, 5'b00000);
    check("reset_credit", bus.credit_remain_o, 3'b000);
    set_weights(2, 1, 3);
    bus.req_i = 3'b111;
    bus.grant_ready_i = 1'b1;
    rst = 1'b0;
    step_check("seq1[0]", t1[0]);
    check("seq1_credit", bus.credit_remain_o, 3'b111);
    for (int i = 1; i < 15; i++) step_check($sformatf("seq1[%0d]", i), t1[i]);

    // Test 2: ready held low keeps the grant stable without consuming credit.
    apply_reset();
    set_weights(1, 1, 1);
    bus.req_i = 3'b111;
    rst = 1'b0;
    step_check("stall_reload", 5'b10000);
    step_check("stall_first", 5'b01001);
    for (int i = 0; i < 5; i++) begin
      step_check($sformatf("stall_hold[%0d]", i), 5'b01001);
      check($sformatf("stall_credit[%0d]", i), bus.credit_remain_o, 3'b111);
    end
    bus.grant_ready_i = 1'b1;
    step_check("stall_hs", 5'b00000);
    check("stall_hs_credit", bus.credit_remain_o, 3'b110);
    step_check("stall_next", 5'b01010);

    // Test 3: weight 0 masks requester 1.
    apply_reset();
    set_weights(3, 0, 2);
    bus.req_i = 3'b111;
    bus.grant_ready_i = 1'b1;
    rst = 1'b0;
    step_check("mask[0]", t3[0]);
    check("mask_credit", bus.credit_remain_o, 3'b101);
    for (int i = 1; i < 10; i++) step_check($sformatf("mask[%0d]", i), t3[i]);

    // Test 4: withdrawal of requester 2 with ready low, then wrap to requester 0.
    apply_reset();
    set_weights(1, 1, 1);
    bus.req_i = 3'b100;
    rst = 1'b0;
    step_check("wd_reload", 5'b10000);
    step_check("wd_grant", 5'b01100);
    step_check("wd_hold", 5'b01100);
    bus.req_i = 3'b001;
    step_check("wd_release", 5'b00000);
    check("wd_credit", bus.credit_remain_o, 3'b111);
    step_check("wd_wrap", 5'b01001);

    // Test 5: reset mid-burst clears credit; the next round reloads full weight.
    apply_reset();
    set_weights(3, 1, 1);
    bus.req_i = 3'b001;
    bus.grant_ready_i = 1'b1;
    rst = 1'b0;
    step_check("rb_reload", 5'b10000);
    step_check("rb_g0", 5'b01001);
    step_check("rb_g1", 5'b01001);
    rst = 1'b1;
    step_check("rb_reset", 5'b00000);
    check("rb_reset_credit", bus.credit_remain_o, 3'b000);
    rst = 1'b0;
    step_check("rb_reload2", 5'b10000);
    check("rb_reload2_credit", bus.credit_remain_o, 3'b111);
    step_check("rb_b0", 5'b01001);
    step_check("rb_b1", 5'b01001);
    step_check("rb_b2", 5'b01001);
    step_check("rb_end", 5'b00000);

`ifdef ARB_ROUND_CNT_EN
    // Test 6: round counter counts pulses; clear during the fourth pulse wins.
    apply_reset();
    check("cnt_reset", bus.round_cnt_o, 16'd0);
    set_weights(1, 0, 0);
    bus.req_i = 3'b001;
    bus.grant_ready_i = 1'b1;
    rst = 1'b0;
    for (int r = 0; r < 3; r++) begin
      step_check($sformatf("cnt_comp[%0d]", r), 5'b10000);
      step_check($sformatf("cnt_grant[%0d]", r), 5'b01001);
      check($sformatf("cnt_val[%0d]", r), bus.round_cnt_o, 32'(r + 1));
      step_check($sformatf("cnt_idle[%0d]", r), 5'b00000);
    end
    step_check("cnt_comp4", 5'b10000);
    check("cnt_before_clr", bus.round_cnt_o, 16'd3);
    bus.round_cnt_clr_i = 1'b1;
    step_check("cnt_clr_grant", 5'b01001);
    check("cnt_cleared", bus.round_cnt_o, 16'd0);
    bus.round_cnt_clr_i = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
